// File: rtl/run_length_detector_if.sv
// Bundle for the run_length_detector's sample inputs and its status outputs.
// The master side drives the samples; the detector attaches as the slave side.
interface run_length_detector_if #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int LW      = $clog2(RUN_LEN + 1)
);
    logic               en;
    logic               din;
    logic [1:0]         mode;
    logic               overlap;
    logic               match;
    logic               match_val;
    logic [LW-1:0]      run_len;
    logic [RUN_LEN-1:0] hist;
    logic [CNT_W-1:0]   det_count;

    modport master (
        output en, din, mode, overlap,
        input  match, match_val, run_len, hist, det_count
    );

    modport slave (
        input  en, din, mode, overlap,
        output match, match_val, run_len, hist, det_count
    );
endinterface

// File: rtl/run_length_detector.sv
// Serial run/pattern detector. It tracks the length of the current qualifying run
// and raises a registered match when RUN_LEN samples have been seen.
module run_length_detector #(
    parameter  int RUN_LEN = 4,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(RUN_LEN + 1)
) (
    input logic                   clk,
    input logic                   rst,
    run_length_detector_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_EQ    = 2'b00,
        MODE_ONES  = 2'b01,
        MODE_ZEROS = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    localparam logic [LW-1:0]    RUN_MAX = LW'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               match_q, match_val_q, last_bit_q, valid_q, overlap_unused;
    logic [LW-1:0]      run_len_q;
    logic [RUN_LEN-1:0] hist_q;
    logic [CNT_W-1:0]   det_count_q;
    mode_e              mode_q;

    mode_e              mode_in;
    logic               cont, restart, qualifier, match_n;
    logic [LW-1:0]      run_n;

    assign mode_in        = mode_e'(bus.mode);
    assign overlap_unused = 1'b0;

    // NOTE: always_comb gives every signal a default first so no path can infer a latch.
    always_comb begin
        cont      = 1'b0;
        qualifier = 1'b1;
        restart   = 1'b0;
        run_n     = run_len_q;
        match_n   = 1'b0;

        if (mode_in == MODE_ALT) cont = (bus.din != last_bit_q);
        else                     cont = (bus.din == last_bit_q);

        unique case (mode_in)
            MODE_ONES:  qualifier = bus.din;
            MODE_ZEROS: qualifier = ~bus.din;
            default:    qualifier = 1'b1;
        endcase

        // A consumed run in non-overlapping mode restarts even if the pattern continues.
        restart = !valid_q || !cont || (mode_in != mode_q) || (!bus.overlap && match_q);

        if (restart)                  run_n = LW'(1);
        else if (run_len_q < RUN_MAX) run_n = run_len_q + LW'(1);
        else                          run_n = RUN_MAX;

        match_n = bus.en && (run_n == RUN_MAX) && qualifier;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q     <= 1'b0;
            match_val_q <= 1'b0;
            run_len_q   <= '0;
            hist_q      <= '0;
            det_count_q <= '0;
            last_bit_q  <= 1'b0;
            valid_q     <= 1'b0;
            mode_q      <= MODE_EQ;
        end else begin
            match_q <= match_n;
            if (bus.en) begin
                hist_q     <= {hist_q[RUN_LEN-2:0], bus.din};
                last_bit_q <= bus.din;
                valid_q    <= 1'b1;
                run_len_q  <= run_n;
                mode_q     <= mode_in;
                if (match_n) begin
                    match_val_q <= bus.din;
                    if (det_count_q != CNT_MAX) det_count_q <= det_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.match     = match_q;
    assign bus.match_val = match_val_q;
    assign bus.run_len   = run_len_q;
    assign bus.hist      = hist_q;
    assign bus.det_count = det_count_q;

endmodule
